mbist_sequencer: RTL

//  Top-level scheduler for the mbist engine. It steps the engine through every enabled

---
 rtl/mbist_sequencer_if.sv | 36 +++
 rtl/mbist_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_sequencer_if.sv
// Purpose : bundles the control, status and engine-facing signals of the
//           mbist sequencer so the SoC side and the sequencer share one port.
// Signals : start/abort/pat_mask/single_mode/single_addr - SoC test controls
//           bist_done/bist_fail                            - engine status
//           bist_cfg                                       - config word to engine
//           busy/seq_done/fail_vec/ran_vec/timeout_err/aborted - sequence results
// Modports: master - the side that drives controls and engine status
//           slave  - the sequencer itself
interface mbist_sequencer_if #(
    parameter int ADDR_BITS = 5
) ();
    logic                   start;
    logic                   abort;
    logic [3:0]             pat_mask;
    logic                   single_mode;
    logic [ADDR_BITS-1:0]   single_addr;
    logic                   bist_done;
    logic                   bist_fail;
    logic [ADDR_BITS+5:0]   bist_cfg;
    logic                   busy;
    logic                   seq_done;
    logic [3:0]             fail_vec;
    logic [3:0]             ran_vec;
    logic                   timeout_err;
    logic                   aborted;

    modport master (
        output start, abort, pat_mask, single_mode, single_addr, bist_done, bist_fail,
        input  bist_cfg, busy, seq_done, fail_vec, ran_vec, timeout_err, aborted
    );

    modport slave (
        input  start, abort, pat_mask, single_mode, single_addr, bist_done, bist_fail,
        output bist_cfg, busy, seq_done, fail_vec, ran_vec, timeout_err, aborted
    );
endinterface

// File: rtl/mbist_sequencer.sv
// Purpose : schedules the mbist engine through every enabled pattern
//           (0 all-zero, 1 all-one, 2 checkerboard, 3 LFSR/MISR), records a
//           pass/fail bit per pattern and recovers from a hung engine.
// Ports   : clk  - single clock
//           rst  - asynchronous active-low reset
//           bus  - mbist_sequencer_if.slave (controls in, cfg and results out)
// Config word: {pattern[1:0], addr[ADDR_BITS-1:0], 2'b00, init, mode}
module mbist_sequencer #(
    parameter int ADDR_BITS = 5,
    parameter int TO_BITS   = 12,
    parameter int TIMEOUT   = 2047
) (
    input  logic              clk,
    input  logic              rst,
    mbist_sequencer_if.slave  bus
);
    localparam int CFG_BITS = ADDR_BITS + 6;
    localparam logic [TO_BITS-1:0] TIMEOUT_C = TO_BITS'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_RUN    = 3'd2,
        ST_CLEAR  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    state_t                 state_r,       state_nxt_s;
    logic [3:0]             mask_r,        mask_nxt_s;
    logic                   mode_r,        mode_nxt_s;
    logic [ADDR_BITS-1:0]   addr_r,        addr_nxt_s;
    logic [1:0]             cur_pat_r,     cur_pat_nxt_s;
    logic [TO_BITS-1:0]     to_cnt_r,      to_cnt_nxt_s;
    logic                   abort_pend_r,  abort_pend_nxt_s;
    logic [CFG_BITS-1:0]    cfg_r,         cfg_nxt_s;
    logic                   busy_r,        busy_nxt_s;
    logic                   seq_done_r,    seq_done_nxt_s;
    logic [3:0]             fail_vec_r,    fail_vec_nxt_s;
    logic [3:0]             ran_vec_r,     ran_vec_nxt_s;
    logic                   timeout_err_r, timeout_err_nxt_s;
    logic                   aborted_r,     aborted_nxt_s;
    logic                   found_s;
    logic [1:0]             sel_pat_s;

    // Returns {found, index} of the lowest enabled pattern at or above 'from'.
    function automatic logic [2:0] find_next(input logic [3:0] mask, input logic [1:0] from);
        logic [2:0] res;
        res = 3'b000;
        // Scan downwards so the lowest qualifying index is written last.
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (2'(i) >= from)) begin
                res = {1'b1, 2'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Packs the engine configuration word.
    function automatic logic [CFG_BITS-1:0] make_cfg(input logic [1:0] pat,
                                                     input logic [ADDR_BITS-1:0] addr,
                                                     input logic init,
                                                     input logic mode);
        return {pat, addr, 2'b00, init, mode};
    endfunction

    assign {found_s, sel_pat_s} = find_next(mask_r, cur_pat_r);

    // Next-state and next-register logic for the sequencing FSM.
    always_comb begin
        state_nxt_s       = state_r;
        mask_nxt_s        = mask_r;
        mode_nxt_s        = mode_r;
        addr_nxt_s        = addr_r;
        cur_pat_nxt_s     = cur_pat_r;
        to_cnt_nxt_s      = to_cnt_r;
        abort_pend_nxt_s  = abort_pend_r;
        cfg_nxt_s         = cfg_r;
        busy_nxt_s        = busy_r;
        seq_done_nxt_s    = 1'b0;
        fail_vec_nxt_s    = fail_vec_r;
        ran_vec_nxt_s     = ran_vec_r;
        timeout_err_nxt_s = timeout_err_r;
        aborted_nxt_s     = aborted_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    mask_nxt_s        = bus.pat_mask;
                    mode_nxt_s        = bus.single_mode;
                    addr_nxt_s        = bus.single_addr;
                    cur_pat_nxt_s     = 2'd0;
                    to_cnt_nxt_s      = '0;
                    abort_pend_nxt_s  = 1'b0;
                    fail_vec_nxt_s    = 4'b0000;
                    ran_vec_nxt_s     = 4'b0000;
                    timeout_err_nxt_s = 1'b0;
                    aborted_nxt_s     = 1'b0;
                    busy_nxt_s        = 1'b1;
                    state_nxt_s       = ST_SELECT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_SELECT: begin
                to_cnt_nxt_s = '0;
                if (bus.abort) begin
                    // cfg already has init=0 here, so it is simply held.
                    aborted_nxt_s    = 1'b1;
                    abort_pend_nxt_s = 1'b1;
                    state_nxt_s      = ST_CLEAR;
                end else if (found_s) begin
                    cur_pat_nxt_s = sel_pat_s;
                    cfg_nxt_s     = make_cfg(sel_pat_s, addr_r, 1'b1, mode_r);
                    state_nxt_s   = ST_RUN;
                end else begin
                    busy_nxt_s     = 1'b0;
                    seq_done_nxt_s = 1'b1;
                    cfg_nxt_s      = '0;
                    state_nxt_s    = ST_FINISH;
                end
            end

            ST_RUN: begin
                to_cnt_nxt_s = to_cnt_r + TO_BITS'(1);
                if (bus.abort) begin
                    aborted_nxt_s    = 1'b1;
                    abort_pend_nxt_s = 1'b1;
                    to_cnt_nxt_s     = '0;
                    cfg_nxt_s        = make_cfg(cur_pat_r, addr_r, 1'b0, mode_r);
                    state_nxt_s      = ST_CLEAR;
                end else if (bus.bist_done) begin
                    fail_vec_nxt_s[cur_pat_r] = bus.bist_fail;
                    ran_vec_nxt_s[cur_pat_r]  = 1'b1;
                    to_cnt_nxt_s              = '0;
                    cfg_nxt_s                 = make_cfg(cur_pat_r, addr_r, 1'b0, mode_r);
                    state_nxt_s               = ST_CLEAR;
                end else if (to_cnt_r == TIMEOUT_C) begin
                    // Engine hung: count the pattern as run and failed.
                    fail_vec_nxt_s[cur_pat_r] = 1'b1;
                    ran_vec_nxt_s[cur_pat_r]  = 1'b1;
                    timeout_err_nxt_s         = 1'b1;
                    to_cnt_nxt_s              = '0;
                    cfg_nxt_s                 = make_cfg(cur_pat_r, addr_r, 1'b0, mode_r);
                    state_nxt_s               = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end

            ST_CLEAR: begin
                to_cnt_nxt_s = to_cnt_r + TO_BITS'(1);
                if (bus.abort) begin
                    aborted_nxt_s    = 1'b1;
                    abort_pend_nxt_s = 1'b1;
                end else begin
                    aborted_nxt_s    = aborted_r;
                    abort_pend_nxt_s = abort_pend_r;
                end
                if (!bus.bist_done) begin
                    // Engine is back in idle; it is safe to move on.
                    if (abort_pend_r || bus.abort || (cur_pat_r == 2'd3)) begin
                        busy_nxt_s     = 1'b0;
                        seq_done_nxt_s = 1'b1;
                        cfg_nxt_s      = '0;
                        state_nxt_s    = ST_FINISH;
                    end else begin
                        cur_pat_nxt_s = cur_pat_r + 2'd1;
                        state_nxt_s   = ST_SELECT;
                    end
                end else if (to_cnt_r == TIMEOUT_C) begin
                    timeout_err_nxt_s = 1'b1;
                    busy_nxt_s        = 1'b0;
                    seq_done_nxt_s    = 1'b1;
                    cfg_nxt_s         = '0;
                    state_nxt_s       = ST_FINISH;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end

            ST_FINISH: begin
                state_nxt_s = ST_IDLE;
            end

            default: begin
                busy_nxt_s  = 1'b0;
                cfg_nxt_s   = '0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            mask_r        <= 4'b0000;
            mode_r        <= 1'b0;
            addr_r        <= '0;
            cur_pat_r     <= 2'd0;
            to_cnt_r      <= '0;
            abort_pend_r  <= 1'b0;
            cfg_r         <= '0;
            busy_r        <= 1'b0;
            seq_done_r    <= 1'b0;
            fail_vec_r    <= 4'b0000;
            ran_vec_r     <= 4'b0000;
            timeout_err_r <= 1'b0;
            aborted_r     <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            mask_r        <= mask_nxt_s;
            mode_r        <= mode_nxt_s;
            addr_r        <= addr_nxt_s;
            cur_pat_r     <= cur_pat_nxt_s;
            to_cnt_r      <= to_cnt_nxt_s;
            abort_pend_r  <= abort_pend_nxt_s;
            cfg_r         <= cfg_nxt_s;
            busy_r        <= busy_nxt_s;
            seq_done_r    <= seq_done_nxt_s;
            fail_vec_r    <= fail_vec_nxt_s;
            ran_vec_r     <= ran_vec_nxt_s;
            timeout_err_r <= timeout_err_nxt_s;
            aborted_r     <= aborted_nxt_s;
        end
    end

    assign bus.bist_cfg    = cfg_r;
    assign bus.busy        = busy_r;
    assign bus.seq_done    = seq_done_r;
    assign bus.fail_vec    = fail_vec_r;
    assign bus.ran_vec     = ran_vec_r;
    assign bus.timeout_err = timeout_err_r;
    assign bus.aborted     = aborted_r;
endmodule
